mult_int_unsign_seq: RTL and testbench

//  Sequential unsigned integer multiplier; the inverse-operation companion to the team's

---
 rtl/mult_int_unsign_seq.sv | 60 ++++++
 tb/tb_mult_int_unsign_seq.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mult_int_unsign_seq.sv
// mult_int_unsign_seq: unsigned shift-add multiplier, one partial product per clock,
// sharing the A/Q/M register layout of the restoring divider.
module mult_int_unsign_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   mcd,
    input  logic [WIDTH-1:0]   mpr,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] prd
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH:0]   a, a_n, sum;
    logic [WIDTH-1:0] q, q_n, m;
    logic [CW-1:0]    count;
    logic             last;

    // A carries into its top bit so the add never loses a bit before the shift
    always_comb begin
        ready   = state == IDLE;
        done    = state == DONE;
        sum     = q[0] ? a + {1'b0, m} : a;
        a_n     = {1'b0, sum[WIDTH:1]};
        q_n     = {sum[0], q[WIDTH-1:1]};
        last    = count == CW'(WIDTH - 1);
        state_n = state == IDLE ? (start ? RUN : IDLE) :
                  state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            a     <= '0;
            q     <= '0;
            m     <= '0;
            count <= '0;
            prd   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                m     <= mcd;
                q     <= mpr;
                a     <= '0;
                count <= '0;
            end else if (state == RUN) begin
                a     <= a_n;
                q     <= q_n;
                count <= count + CW'(1);
                if (last) prd <= {a_n[WIDTH-1:0], q_n};
            end
        end
    end
endmodule

// File: tb/tb_mult_int_unsign_seq.sv
// Scoreboard bench: the driver queues expected product and done cycle per accepted op,
// the monitor pops and checks on every done pulse and watches prd stability.
module tb_mult_int_unsign_seq;
    localparam int W = 8;

    logic           clk = 0;
    logic           reset_n = 0;
    logic           start = 0;
    logic [W-1:0]   mcd = '0, mpr = '0;
    logic           ready, done;
    logic [2*W-1:0] prd;

    int checks = 0, errors = 0, cyc = 0;
    logic [2*W-1:0] exp_prd_q[$];
    int             exp_cyc_q[$];
    logic [2*W-1:0] last_prd = '0;

    mult_int_unsign_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mcd(mcd), .mpr(mpr),
        .ready(ready), .done(done), .prd(prd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor
    always @(negedge clk) begin
        if (!reset_n) begin
            last_prd = '0;
            exp_prd_q.delete();
            exp_cyc_q.delete();
        end else if (done) begin
            checks++;
            if (exp_prd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done=1 at cycle %0d with nothing pending, prd=%0d", cyc, prd);
            end else begin
                logic [2*W-1:0] ep;
                int             ec;
                ep = exp_prd_q.pop_front();
                ec = exp_cyc_q.pop_front();
                if (prd !== ep) begin
                    errors++;
                    $display("FAIL product: got %0d expected %0d", prd, ep);
                end
                checks++;
                if (cyc != ec) begin
                    errors++;
                    $display("FAIL latency: done at cycle %0d expected cycle %0d", cyc, ec);
                end
            end
            last_prd = prd;
        end else if (prd !== last_prd) begin
            checks++;
            errors++;
            $display("FAIL prd_stable: prd changed to %0d from %0d without done", prd, last_prd);
            last_prd = prd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 4 * W) begin
            tick();
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%0b after %0d cycles, expected 1", ready, n);
        end
    endtask

    // issue one op; push expectation only when the request is meant to execute
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] e, input bit push);
        wait_ready();
        mcd   = a;
        mpr   = b;
        start = 1;
        if (push) begin
            exp_prd_q.push_back(e);
            exp_cyc_q.push_back(cyc + 1 + W);
        end
        tick();
        start = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_prd_q.size() != 0 && n < 8 * W) begin
            tick();
            n++;
        end
        chk("drain_pending", exp_prd_q.size(), 0);
    endtask

    initial begin
        int acc_prev, acc_now;
        tick();
        tick();
        reset_n = 0;
        tick();
        chk("reset_ready", ready, 1);
        chk("reset_done", done, 0);
        chk("reset_prd", prd, 0);
        reset_n = 1;

        // basic and corners
        op(8'd13, 8'd11, 16'd143, 1);
        tick();
        chk("busy_ready", ready, 0);
        drain();
        op(8'd255, 8'd255, 16'hFE01, 1);
        op(8'd0, 8'd200, 16'd0, 1);
        op(8'd200, 8'd0, 16'd0, 1);
        op(8'd1, 8'd173, 16'd173, 1);
        op(8'd173, 8'd1, 16'd173, 1);
        op(8'd128, 8'd2, 16'd256, 1);
        op(8'd15, 8'd17, 16'd255, 1);
        drain();

        // start during RUN is ignored
        op(8'd7, 8'd9, 16'd63, 1);
        tick();
        tick();
        mcd   = 8'd3;
        mpr   = 8'd3;
        start = 1;
        tick();
        start = 0;
        drain();
        repeat (W + 4) tick();
        chk("ignored_prd", prd, 63);

        // reset in the middle of an op
        op(8'd100, 8'd100, 16'd10000, 0);
        repeat (3) tick();
        reset_n = 0;
        tick();
        reset_n = 1;
        chk("abort_ready", ready, 1);
        chk("abort_prd", prd, 0);
        repeat (W + 4) tick();
        chk("abort_prd_hold", prd, 0);
        op(8'd5, 8'd6, 16'd30, 1);
        drain();

        // back-to-back with start held high
        start    = 1;
        acc_prev = -1;
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] a, b;
            a = W'(20 + 37 * i);
            b = W'(3 + 50 * i);
            wait_ready();
            mcd = a;
            mpr = b;
            exp_prd_q.push_back(16'(a) * 16'(b));
            exp_cyc_q.push_back(cyc + 1 + W);
            acc_now = cyc + 1;
            if (acc_prev >= 0) chk("b2b_spacing", acc_now - acc_prev, W + 2);
            acc_prev = acc_now;
            tick();
        end
        start = 0;
        drain();

        // random operands against a*b
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = W'($urandom);
            op(a, b, 16'(a) * 16'(b), 1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
